// File: rtl/instr_type_pkg.sv
`default_nettype none
// ============================================================
// Package : instr_type_pkg
// Brief   : RV32I instruction kinds, opcodes and decoded record
// Rev     : 1.0
// ============================================================
package instr_type_pkg;

  // K_INVALID is zero so a cleared record reads as Invalid.
  typedef enum logic [5:0] {
    K_INVALID = 6'd0,
    K_LUI, K_AUIPC, K_JAL, K_JALR,
    K_BEQ, K_BNE, K_BLT, K_BGE, K_BLTU, K_BGEU,
    K_LB, K_LH, K_LW, K_LBU, K_LHU,
    K_SB, K_SH, K_SW,
    K_ADDI, K_SLTI, K_SLTIU, K_XORI, K_ORI, K_ANDI, K_SLLI, K_SRLI, K_SRAI,
    K_ADD, K_SUB, K_SLL, K_SLT, K_SLTU, K_XOR, K_SRL, K_SRA, K_OR, K_AND,
    K_FENCE, K_FENCE_I, K_ECALL, K_EBREAK,
    K_CSRRW, K_CSRRS, K_CSRRC, K_CSRRWI, K_CSRRSI, K_CSRRCI
  } instr_kind_t;

  // Which register fields and immediate an instruction carries.
  typedef enum logic [3:0] {
    FMT_NONE = 4'd0,
    FMT_R, FMT_I, FMT_IZ, FMT_S, FMT_B, FMT_U, FMT_J, FMT_CSR
  } field_fmt_t;

  localparam logic [6:0] c_opc_lui      = 7'b0110111;
  localparam logic [6:0] c_opc_auipc    = 7'b0010111;
  localparam logic [6:0] c_opc_jal      = 7'b1101111;
  localparam logic [6:0] c_opc_jalr     = 7'b1100111;
  localparam logic [6:0] c_opc_branch   = 7'b1100011;
  localparam logic [6:0] c_opc_load     = 7'b0000011;
  localparam logic [6:0] c_opc_store    = 7'b0100011;
  localparam logic [6:0] c_opc_op_imm   = 7'b0010011;
  localparam logic [6:0] c_opc_op       = 7'b0110011;
  localparam logic [6:0] c_opc_misc_mem = 7'b0001111;
  localparam logic [6:0] c_opc_system   = 7'b1110011;

  typedef struct packed {
    instr_kind_t kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        illegal;
  } decoded_instr_t;

endpackage
`default_nettype wire

// File: rtl/instr_decoder.sv
`default_nettype none
// ============================================================
// Module  : instr_decoder
// Brief   : purely combinational RV32I instruction decode
// Rev     : 1.0
// ============================================================
module instr_decoder
  import instr_type_pkg::*;
(
  input  logic [31:0]    instr,
  output decoded_instr_t dec
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_csr;
  instr_kind_t w_kind;
  field_fmt_t  w_fmt;

  assign w_opcode  = instr[6:0];
  assign w_funct3  = instr[14:12];
  assign w_funct7  = instr[31:25];
  assign w_imm_i   = {{20{instr[31]}}, instr[31:20]};
  assign w_imm_s   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign w_imm_b   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign w_imm_u   = {instr[31:12], 12'd0};
  assign w_imm_j   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign w_imm_csr = {20'd0, instr[31:20]};

  always_comb begin
    w_kind = K_INVALID;
    w_fmt  = FMT_NONE;
    case (w_opcode)
      c_opc_lui:   begin w_kind = K_LUI;   w_fmt = FMT_U; end
      c_opc_auipc: begin w_kind = K_AUIPC; w_fmt = FMT_U; end
      c_opc_jal:   begin w_kind = K_JAL;   w_fmt = FMT_J; end
      c_opc_jalr: begin
        w_fmt = FMT_I;
        if (w_funct3 == 3'b000) w_kind = K_JALR;
      end
      c_opc_branch: begin
        w_fmt = FMT_B;
        case (w_funct3)
          3'b000:  w_kind = K_BEQ;
          3'b001:  w_kind = K_BNE;
          3'b100:  w_kind = K_BLT;
          3'b101:  w_kind = K_BGE;
          3'b110:  w_kind = K_BLTU;
          3'b111:  w_kind = K_BGEU;
          default: ;
        endcase
      end
      c_opc_load: begin
        w_fmt = FMT_I;
        case (w_funct3)
          3'b000:  w_kind = K_LB;
          3'b001:  w_kind = K_LH;
          3'b010:  w_kind = K_LW;
          3'b100:  w_kind = K_LBU;
          3'b101:  w_kind = K_LHU;
          default: ;
        endcase
      end
      c_opc_store: begin
        w_fmt = FMT_S;
        case (w_funct3)
          3'b000:  w_kind = K_SB;
          3'b001:  w_kind = K_SH;
          3'b010:  w_kind = K_SW;
          default: ;
        endcase
      end
      c_opc_op_imm: begin
        w_fmt = FMT_I;
        case (w_funct3)
          3'b000: w_kind = K_ADDI;
          3'b010: w_kind = K_SLTI;
          3'b011: w_kind = K_SLTIU;
          3'b100: w_kind = K_XORI;
          3'b110: w_kind = K_ORI;
          3'b111: w_kind = K_ANDI;
          // Shift-immediates keep funct7 strict so shamt[5] (instr[25]) is rejected.
          3'b001: if (w_funct7 == 7'h00) w_kind = K_SLLI;
          3'b101: begin
            if (w_funct7 == 7'h00)      w_kind = K_SRLI;
            else if (w_funct7 == 7'h20) w_kind = K_SRAI;
          end
          default: ;
        endcase
      end
      c_opc_op: begin
        w_fmt = FMT_R;
        if (w_funct7 == 7'h00) begin
          case (w_funct3)
            3'b000: w_kind = K_ADD;
            3'b001: w_kind = K_SLL;
            3'b010: w_kind = K_SLT;
            3'b011: w_kind = K_SLTU;
            3'b100: w_kind = K_XOR;
            3'b101: w_kind = K_SRL;
            3'b110: w_kind = K_OR;
            3'b111: w_kind = K_AND;
            default: ;
          endcase
        end else if (w_funct7 == 7'h20) begin
          if (w_funct3 == 3'b000)      w_kind = K_SUB;
          else if (w_funct3 == 3'b101) w_kind = K_SRA;
        end
      end
      c_opc_misc_mem: begin
        if (w_funct3 == 3'b000) begin
          w_kind = K_FENCE;
          w_fmt  = FMT_I;
        end else if (w_funct3 == 3'b001) begin
          w_kind = K_FENCE_I;
          w_fmt  = FMT_IZ;
        end
      end
      c_opc_system: begin
        w_fmt = FMT_CSR;
        case (w_funct3)
          3'b000: begin
            w_fmt = FMT_NONE;
            if (instr[31:20] == 12'd0)      w_kind = K_ECALL;
            else if (instr[31:20] == 12'd1) w_kind = K_EBREAK;
          end
          3'b001:  w_kind = K_CSRRW;
          3'b010:  w_kind = K_CSRRS;
          3'b011:  w_kind = K_CSRRC;
          3'b101:  w_kind = K_CSRRWI;
          3'b110:  w_kind = K_CSRRSI;
          3'b111:  w_kind = K_CSRRCI;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    dec.kind    = w_kind;
    dec.illegal = (w_kind == K_INVALID);
    dec.rd      = '0;
    dec.rs1     = '0;
    dec.rs2     = '0;
    dec.imm     = '0;
    if (w_kind != K_INVALID) begin
      case (w_fmt)
        FMT_R:   begin dec.rd = instr[11:7]; dec.rs1 = instr[19:15]; dec.rs2 = instr[24:20]; end
        FMT_I:   begin dec.rd = instr[11:7]; dec.rs1 = instr[19:15]; dec.imm = w_imm_i; end
        FMT_IZ:  begin dec.rd = instr[11:7]; dec.rs1 = instr[19:15]; end
        FMT_S:   begin dec.rs1 = instr[19:15]; dec.rs2 = instr[24:20]; dec.imm = w_imm_s; end
        FMT_B:   begin dec.rs1 = instr[19:15]; dec.rs2 = instr[24:20]; dec.imm = w_imm_b; end
        FMT_U:   begin dec.rd = instr[11:7]; dec.imm = w_imm_u; end
        FMT_J:   begin dec.rd = instr[11:7]; dec.imm = w_imm_j; end
        // CSRRxI reuse the rs1 slot for the 5-bit uimm.
        FMT_CSR: begin dec.rd = instr[11:7]; dec.rs1 = instr[19:15]; dec.imm = w_imm_csr; end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================
// Module  : decode_stage
// Brief   : registered RV32I decode stage with valid/ready flow
// Rev     : 1.0
// ============================================================
module decode_stage
  import instr_type_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [5:0]  out_kind,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [31:0] out_imm,
  output logic        out_illegal
);

  decoded_instr_t w_dec;
  decoded_instr_t r_dec;
  logic           r_valid;
  logic [31:0]    r_pc;
  logic           w_accept;

  instr_decoder u_instr_decoder (
    .instr (in_instr),
    .dec   (w_dec)
  );

  // flush gates in_ready, so an accept can never coincide with a flush.
  assign in_ready = (!r_valid || out_ready) && !flush;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_dec   <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_pc    <= in_pc;
      r_dec   <= w_dec;
    end else if (flush || out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign out_pc      = r_pc;
  assign out_kind    = r_dec.kind;
  assign out_rd      = r_dec.rd;
  assign out_rs1     = r_dec.rs1;
  assign out_rs2     = r_dec.rs2;
  assign out_imm     = r_dec.imm;
  assign out_illegal = r_dec.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================
// Module  : tb_decode_stage
// Brief   : randomized bench for decode_stage with mask/match model
// Rev     : 1.0
// ============================================================
`timescale 1ns/1ps
module tb_decode_stage;
  import instr_type_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [5:0]  out_kind;
  logic [4:0]  out_rd, out_rs1, out_rs2;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_kind(out_kind),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- reference model: riscv-opcodes style mask/match table ----
  localparam int F_NONE = 0, F_R = 1, F_I = 2, F_IZ = 3, F_S = 4, F_B = 5, F_U = 6, F_J = 7, F_CSR = 8;

  logic [31:0] t_mask[$];
  logic [31:0] t_match[$];
  instr_kind_t t_kind[$];
  int          t_fmt[$];

  typedef struct {
    logic [5:0]  kind;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        illegal;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];

  task automatic add(input logic [31:0] m, input logic [31:0] mt, input instr_kind_t k, input int f);
    t_mask.push_back(m); t_match.push_back(mt); t_kind.push_back(k); t_fmt.push_back(f);
  endtask

  task automatic init_table();
    add(32'h7f, 32'h37, K_LUI, F_U);         add(32'h7f, 32'h17, K_AUIPC, F_U);
    add(32'h7f, 32'h6f, K_JAL, F_J);         add(32'h707f, 32'h67, K_JALR, F_I);
    add(32'h707f, 32'h63, K_BEQ, F_B);       add(32'h707f, 32'h1063, K_BNE, F_B);
    add(32'h707f, 32'h4063, K_BLT, F_B);     add(32'h707f, 32'h5063, K_BGE, F_B);
    add(32'h707f, 32'h6063, K_BLTU, F_B);    add(32'h707f, 32'h7063, K_BGEU, F_B);
    add(32'h707f, 32'h03, K_LB, F_I);        add(32'h707f, 32'h1003, K_LH, F_I);
    add(32'h707f, 32'h2003, K_LW, F_I);      add(32'h707f, 32'h4003, K_LBU, F_I);
    add(32'h707f, 32'h5003, K_LHU, F_I);
    add(32'h707f, 32'h23, K_SB, F_S);        add(32'h707f, 32'h1023, K_SH, F_S);
    add(32'h707f, 32'h2023, K_SW, F_S);
    add(32'h707f, 32'h13, K_ADDI, F_I);      add(32'h707f, 32'h2013, K_SLTI, F_I);
    add(32'h707f, 32'h3013, K_SLTIU, F_I);   add(32'h707f, 32'h4013, K_XORI, F_I);
    add(32'h707f, 32'h6013, K_ORI, F_I);     add(32'h707f, 32'h7013, K_ANDI, F_I);
    add(32'hfe00707f, 32'h1013, K_SLLI, F_I);
    add(32'hfe00707f, 32'h5013, K_SRLI, F_I);
    add(32'hfe00707f, 32'h40005013, K_SRAI, F_I);
    add(32'hfe00707f, 32'h33, K_ADD, F_R);   add(32'hfe00707f, 32'h40000033, K_SUB, F_R);
    add(32'hfe00707f, 32'h1033, K_SLL, F_R); add(32'hfe00707f, 32'h2033, K_SLT, F_R);
    add(32'hfe00707f, 32'h3033, K_SLTU, F_R); add(32'hfe00707f, 32'h4033, K_XOR, F_R);
    add(32'hfe00707f, 32'h5033, K_SRL, F_R); add(32'hfe00707f, 32'h40005033, K_SRA, F_R);
    add(32'hfe00707f, 32'h6033, K_OR, F_R);  add(32'hfe00707f, 32'h7033, K_AND, F_R);
    add(32'h707f, 32'h0f, K_FENCE, F_I);     add(32'h707f, 32'h100f, K_FENCE_I, F_IZ);
    add(32'hfff0707f, 32'h73, K_ECALL, F_NONE);
    add(32'hfff0707f, 32'h00100073, K_EBREAK, F_NONE);
    add(32'h707f, 32'h1073, K_CSRRW, F_CSR); add(32'h707f, 32'h2073, K_CSRRS, F_CSR);
    add(32'h707f, 32'h3073, K_CSRRC, F_CSR); add(32'h707f, 32'h5073, K_CSRRWI, F_CSR);
    add(32'h707f, 32'h6073, K_CSRRSI, F_CSR); add(32'h707f, 32'h7073, K_CSRRCI, F_CSR);
  endtask

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    if (v[bits-1]) return v | (~32'd0 << bits);
    return v;
  endfunction

  function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    int   hit = -1;
    e.kind = 6'd0; e.rd = '0; e.rs1 = '0; e.rs2 = '0; e.imm = '0; e.illegal = 1'b1; e.pc = pc;
    for (int i = 0; i < t_mask.size(); i++)
      if ((w & t_mask[i]) == t_match[i]) hit = i;
    if (hit >= 0) begin
      e.kind    = t_kind[hit];
      e.illegal = 1'b0;
      case (t_fmt[hit])
        F_R:   begin e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20]; end
        F_I:   begin e.rd = w[11:7]; e.rs1 = w[19:15]; e.imm = sext(32'(w[31:20]), 12); end
        F_IZ:  begin e.rd = w[11:7]; e.rs1 = w[19:15]; end
        F_S:   begin e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.imm = sext(32'({w[31:25], w[11:7]}), 12); end
        F_B:   begin e.rs1 = w[19:15]; e.rs2 = w[24:20];
                     e.imm = sext(32'({w[31], w[7], w[30:25], w[11:8], 1'b0}), 13); end
        F_U:   begin e.rd = w[11:7]; e.imm = (w >> 12) << 12; end
        F_J:   begin e.rd = w[11:7];
                     e.imm = sext(32'({w[31], w[19:12], w[20], w[30:21], 1'b0}), 21); end
        F_CSR: begin e.rd = w[11:7]; e.rs1 = w[19:15]; e.imm = w >> 20; end
        default: ;
      endcase
    end
    return e;
  endfunction

  // ---- per-cycle scoreboard compare (negedge, inputs stable until next posedge+1) ----
  exp_t h;
  bit   exp_ready;
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_kind", 32'(out_kind), 32'(K_INVALID));
      check("rst_illegal", 32'(out_illegal), 32'd0);
      check("rst_fields", {out_pc | out_imm, 17'd0, out_rd, out_rs1, out_rs2} , 32'd0);
    end else begin
      check("sb_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        h = q[0];
        check("sb_pc", out_pc, h.pc);
        check("sb_kind", 32'(out_kind), 32'(h.kind));
        check("sb_rd", 32'(out_rd), 32'(h.rd));
        check("sb_rs1", 32'(out_rs1), 32'(h.rs1));
        check("sb_rs2", 32'(out_rs2), 32'(h.rs2));
        check("sb_imm", out_imm, h.imm);
        check("sb_illegal", 32'(out_illegal), 32'(h.illegal));
      end
      exp_ready = (q.size() == 0 || out_ready) && !flush;
      check("sb_in_ready", 32'(in_ready), 32'(exp_ready));
      if (flush) q.delete();
      else begin
        if (out_ready && q.size() != 0) void'(q.pop_front());
        if (in_valid && exp_ready) q.push_back(model(in_instr, in_pc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    step(); step();
  endtask

  task automatic offer(input logic [31:0] w, input logic [31:0] pc);
    in_valid = 1'b1; in_instr = w; in_pc = pc;
  endtask

  exp_t m;
  int   idx;
  logic [31:0] w;

  initial begin
    init_table();

    // Pin the model with hand-decoded encodings.
    m = model(32'h00500093, 32'h0);
    check("model_addi_kind", 32'(m.kind), 32'(K_ADDI));
    check("model_addi_imm", m.imm, 32'h5);
    m = model(32'hFE208EE3, 32'h0);
    check("model_beq_kind", 32'(m.kind), 32'(K_BEQ));
    check("model_beq_imm", m.imm, 32'hFFFFFFFC);
    m = model(32'h12345137, 32'h0);
    check("model_lui", {m.imm[31:12], 7'd0, m.rd}, {20'h12345, 7'd0, 5'd2});
    m = model(32'h008000EF, 32'h0);
    check("model_jal_imm", m.imm, 32'h8);
    m = model(32'h3402D0F3, 32'h0);
    check("model_csrrwi", {m.imm[15:0], 1'b0, m.rd, m.rs1, m.rs2},
          {16'h0340, 1'b0, 5'd1, 5'd5, 5'd0});
    check("model_csrrwi_kind", 32'(m.kind), 32'(K_CSRRWI));
    m = model(32'h02009093, 32'h0);
    check("model_slli25", {31'd0, m.illegal} | 32'(m.kind), 32'd1);

    repeat (3) step();
    rst_n = 1'b1;
    #1 check("ready_after_reset", 32'(in_ready), 32'd1);

    // ADDI x1, x0, 5
    offer(32'h00500093, 32'h100); out_ready = 1'b1;
    step(); in_valid = 1'b0;
    check("addi_valid", 32'(out_valid), 32'd1);
    check("addi_kind", 32'(out_kind), 32'(K_ADDI));
    check("addi_regs", {17'd0, out_rd, out_rs1, out_rs2}, {17'd0, 5'd1, 5'd0, 5'd0});
    check("addi_imm", out_imm, 32'h5);
    check("addi_pc", out_pc, 32'h100);

    // BEQ x1, x2, -4
    offer(32'hFE208EE3, 32'h104);
    step(); in_valid = 1'b0;
    check("beq_kind", 32'(out_kind), 32'(K_BEQ));
    check("beq_regs", {17'd0, out_rd, out_rs1, out_rs2}, {17'd0, 5'd0, 5'd1, 5'd2});
    check("beq_imm", out_imm, 32'hFFFFFFFC);

    // Illegal encodings
    offer(32'hFFFFFFFF, 32'h108);
    step();
    check("ill_ff_kind", 32'(out_kind), 32'(K_INVALID));
    check("ill_ff_flag", 32'(out_illegal), 32'd1);
    check("ill_ff_imm", out_imm, 32'd0);
    offer(32'h02009093, 32'h10C);
    step(); in_valid = 1'b0;
    check("ill_slli_kind", 32'(out_kind), 32'(K_INVALID));
    check("ill_slli_flag", 32'(out_illegal), 32'd1);
    check("ill_slli_imm", out_imm, 32'd0);

    // Back-pressure: A held, B waiting for 3 cycles
    drain();
    out_ready = 1'b0;
    offer(32'h00A00113, 32'h300);
    step();
    offer(32'h002081B3, 32'h304);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_pc", out_pc, 32'h300);
      check("stall_kind", 32'(out_kind), 32'(K_ADDI));
      step();
    end
    out_ready = 1'b1;
    step(); in_valid = 1'b0;
    check("release_b_valid", 32'(out_valid), 32'd1);
    check("release_b_pc", out_pc, 32'h304);
    check("release_b_kind", 32'(out_kind), 32'(K_ADD));
    step();
    check("release_empty", 32'(out_valid), 32'd0);

    // Flush with held instruction, new offer and out_ready all high
    drain();
    out_ready = 1'b0;
    offer(32'h00500093, 32'h400);
    step();
    offer(32'h002081B3, 32'h404); out_ready = 1'b1; flush = 1'b1;
    #1 check("flush_in_ready", 32'(in_ready), 32'd0);
    step(); flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", 32'(out_valid), 32'd0);
    step();
    check("flush_not_accepted", 32'(out_valid), 32'd0);

    // Asynchronous reset during a stall
    drain();
    out_ready = 1'b0;
    offer(32'h00A00113, 32'h500);
    step();
    offer(32'h002081B3, 32'h504);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_kind", 32'(out_kind), 32'(K_INVALID));
    check("async_rst_pc", out_pc, 32'd0);
    in_valid = 1'b0;
    step(); step();
    rst_n = 1'b1;
    #1 check("post_rst_ready", 32'(in_ready), 32'd1);
    offer(32'h00500093, 32'h200); out_ready = 1'b1;
    step(); in_valid = 1'b0;
    check("post_rst_kind", 32'(out_kind), 32'(K_ADDI));
    check("post_rst_imm_pc", out_imm ^ out_pc, 32'h205);

    // Randomized traffic checked by the scoreboard
    for (int c = 0; c < 3000; c++) begin
      step();
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      in_pc     = $urandom & 32'hFFFF_FFFC;
      idx       = $urandom_range(0, t_mask.size() - 1);
      w         = ($urandom & ~t_mask[idx]) | t_match[idx];
      case ($urandom_range(0, 3))
        0:       in_instr = $urandom;
        1:       in_instr = w ^ (32'd1 << $urandom_range(0, 31));
        default: in_instr = w;
      endcase
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        #1 check("rand_async_rst", 32'(out_valid), 32'd0);
        step();
        rst_n = 1'b1;
      end
    end

    drain();
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
